param_combination_lock: RTL
===========================

Name: param_combination_lock

Overview:
- Parametrised keypad combination lock FSM for the Basys2 lab platform.
- Accepts a CODE_LEN-digit sequence of one-hot keypad patterns and detects key presses on edges, so a held key counts once.
- Counts failed attempts and enters a timed lockout after MAX_FAILS failures. Abandons partial entry after an idle timeout.
- Drives an LED bargraph progress display plus unlock and lockout flags.

Parameters:
- KEY_W, 4, keypad bus width in bits; each digit is one KEY_W-bit pattern.
- CODE_LEN, 4, number of digits in the combination; legal range 1..8.
- CODE, 16'h4182, reset-time combination (CODE_LEN*KEY_W bits); digit 0 in the LSBs; default encodes keys 2,8,1,4.
- MAX_FAILS, 3, number of wrong digits that triggers lockout; minimum 1.
- LOCKOUT_CYC, 50_000_000, lockout duration in clocks.
- TIMEOUT_CYC, 250_000_000, idle clocks allowed between presses during entry.

Ports:
- Lock_CLK  in  1  system clock (MCLK).
- Lock_RST  in  1  synchronous, active-high reset.
- Key_IN  in  KEY_W  keypad pattern; all-zero means no key; input is already synchronised and debounced.
- Relock_IN  in  1  relock request, honoured only in OPEN.
- Unlocked  out  1  high while in OPEN.
- Locked_out  out  1  high while in LOCKOUT.
- Fail_cnt  out  $clog2(MAX_FAILS+1)  failed attempts since the last success or lockout.
- Progress  out  $clog2(CODE_LEN+1)  number of correct digits entered.
- LED_graph  out  CODE_LEN  thermometer of Progress; LED_graph[i] = (Progress > i).

Behaviour:
- Reset: one clock, synchronous, active-high. On a clock edge with Lock_RST=1:
  - state goes to IDLE;
  - Progress, Fail_cnt, LED_graph, timers and the key_prev register clear to 0;
  - Unlocked and Locked_out go to 0.
  - Reset mid-entry, mid-lockout or while OPEN has identical effect.
- Press detection:
  - press = (Key_IN != 0) && (key_prev == 0); key_prev is updated every cycle.
  - The full KEY_W pattern is compared against the expected digit, so a multi-key pattern never matches a one-hot digit.
- Outputs are registered and update on the same edge as the state, giving one clock of latency from the sampled press.
- IDLE:
  - press == digit 0 → ENTRY with Progress=1; if CODE_LEN==1, go straight to OPEN.
  - Any other press is ignored and not counted as a failure.
- ENTRY:
  - Correct press on digit Progress → Progress+1 and timeout timer cleared.
  - Correct final digit → OPEN, Progress=CODE_LEN, Fail_cnt=0.
  - Wrong press → IDLE, Progress=0, Fail_cnt+1. If the new Fail_cnt equals MAX_FAILS, go to LOCKOUT on that same edge.
  - No press for TIMEOUT_CYC consecutive clocks → IDLE, Progress=0, Fail_cnt unchanged.
- OPEN:
  - Unlocked=1 and LED_graph is all ones; presses are ignored.
  - Relock_IN=1 → IDLE, Progress=0. If Relock_IN and a press occur in the same cycle, the relock wins.
- LOCKOUT:
  - Locked_out=1, Progress=0; all presses are ignored.
  - After exactly LOCKOUT_CYC clocks → IDLE with Fail_cnt=0.
- Fail_cnt saturates at MAX_FAILS and never wraps.
- Timers are sized $clog2 of their terminal count and do not wrap.
- Unused or illegal state encodings → IDLE on the next edge.

Optional Feature:
- Macro: LOCK_REPROGRAM_EN.
- Defined:
  - Adds ports Code_IN (in, CODE_LEN*KEY_W) and Prog_IN (in, 1).
  - The combination is held in an internal register, loaded with CODE on reset.
  - In OPEN, Prog_IN=1 loads Code_IN into that register on the same edge. The state stays OPEN.
  - If Prog_IN and Relock_IN are both high, the new code is loaded and the state then goes to IDLE.
  - Prog_IN is ignored in every state other than OPEN.
- Undefined: neither port exists, and the combination is the constant CODE.

Test Plan:
1. Defaults: press 2,8,1,4, each held 3 clocks with a release between → Progress 1,2,3,4; Unlocked=1 one clock after the 4 is sampled; LED_graph=4'b1111; Fail_cnt=0. Then Relock_IN pulse → Unlocked=0, Progress=0.
2. Press 2, hold for 10 clocks, release, press 2 again, then 8 → the held 2 counts once, the second 2 is a wrong digit → IDLE, Fail_cnt=1; the following 8 is ignored in IDLE.
3. With LOCKOUT_CYC=16, make three wrong attempts (2 then 4) → Fail_cnt=3 and Locked_out=1; presses are ignored for 16 clocks, then Locked_out=0 and Fail_cnt=0.
4. With TIMEOUT_CYC=20, press 2,8 then idle 20 clocks → Progress returns to 0 and Fail_cnt is unchanged.
5. Assert Lock_RST for one clock while Progress=3 → all outputs are 0 on the next clock, and 2,8,1,4 then unlocks normally.
6. With LOCK_REPROGRAM_EN: unlock, then apply Prog_IN with Code_IN=16'h1111 → after relock, 1,1,1,1 (with releases) unlocks and 2,8,1,4 does not.

Source files
------------

// File: rtl/param_combination_lock.sv
// Keypad combination lock: edge-detected digit entry, fail counting,
// timed lockout and idle timeout. Optional macro: LOCK_REPROGRAM_EN.
module param_combination_lock #(
    parameter int KEY_W       = 4,
    parameter int CODE_LEN    = 4,
    parameter logic [CODE_LEN*KEY_W-1:0] CODE = 16'h4182,
    parameter int MAX_FAILS   = 3,
    parameter int LOCKOUT_CYC = 50_000_000,
    parameter int TIMEOUT_CYC = 250_000_000
) (
    input  logic                             Lock_CLK,
    input  logic                             Lock_RST,
    input  logic [KEY_W-1:0]                 Key_IN,
    input  logic                             Relock_IN,
`ifdef LOCK_REPROGRAM_EN
    input  logic [CODE_LEN*KEY_W-1:0]        Code_IN,
    input  logic                             Prog_IN,
`endif
    output logic                             Unlocked,
    output logic                             Locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0]   Fail_cnt,
    output logic [$clog2(CODE_LEN+1)-1:0]    Progress,
    output logic [CODE_LEN-1:0]              LED_graph
);

    localparam int PW = $clog2(CODE_LEN + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int LW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_OPEN  = 2'd2,
        S_LOCK  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [PW-1:0]             prog_q, prog_d;
    logic [FW-1:0]             fail_q, fail_d;
    logic [TW-1:0]             tmo_q, tmo_d;
    logic [LW-1:0]             lck_q, lck_d;
    logic [KEY_W-1:0]          kprev_q;
    logic [CODE_LEN*KEY_W-1:0] code_w;
    logic [KEY_W-1:0]          exp_dig;
    logic                      press;
    logic                      hit;

`ifdef LOCK_REPROGRAM_EN
    logic [CODE_LEN*KEY_W-1:0] code_q, code_d;
    assign code_w = code_q;
`else
    assign code_w = CODE;
`endif

    function automatic logic [CODE_LEN-1:0] therm(input logic [PW-1:0] p);
        logic [CODE_LEN-1:0] t;
        t = '0;
        for (int i = 0; i < CODE_LEN; i++)
            t[i] = (p > PW'(i));
        return t;
    endfunction

    // Select the digit expected at the current entry position.
    always_comb begin
        exp_dig = '0;
        for (int i = 0; i < CODE_LEN; i++)
            if (prog_q == PW'(i))
                exp_dig = code_w[i*KEY_W +: KEY_W];
    end

    assign press = (Key_IN != '0) && (kprev_q == '0);
    assign hit   = press && (Key_IN == exp_dig);

    // Next-state and counter logic for the lock FSM.
    always_comb begin
        state_d = state_q;
        prog_d  = prog_q;
        fail_d  = fail_q;
        tmo_d   = tmo_q;
        lck_d   = lck_q;
`ifdef LOCK_REPROGRAM_EN
        code_d  = code_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    tmo_d = '0;
                    if (CODE_LEN == 1) begin
                        state_d = S_OPEN;
                        prog_d  = PW'(CODE_LEN);
                        fail_d  = '0;
                    end else begin
                        state_d = S_ENTRY;
                        prog_d  = PW'(1);
                    end
                end
            end
            S_ENTRY: begin
                if (hit) begin
                    tmo_d  = '0;
                    prog_d = prog_q + 1'b1;
                    if (prog_q == PW'(CODE_LEN - 1)) begin
                        state_d = S_OPEN;
                        fail_d  = '0;
                    end
                end else if (press) begin
                    state_d = S_IDLE;
                    prog_d  = '0;
                    tmo_d   = '0;
                    if (fail_q != FW'(MAX_FAILS))
                        fail_d = fail_q + 1'b1;
                    if (fail_d == FW'(MAX_FAILS)) begin
                        state_d = S_LOCK;
                        lck_d   = '0;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d = S_IDLE;
                    prog_d  = '0;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_OPEN: begin
`ifdef LOCK_REPROGRAM_EN
                if (Prog_IN)
                    code_d = Code_IN;
`endif
                if (Relock_IN) begin
                    state_d = S_IDLE;
                    prog_d  = '0;
                end
            end
            S_LOCK: begin
                prog_d = '0;
                if (lck_q == LW'(LOCKOUT_CYC - 1)) begin
                    state_d = S_IDLE;
                    fail_d  = '0;
                    lck_d   = '0;
                end else begin
                    lck_d = lck_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                prog_d  = '0;
                tmo_d   = '0;
                lck_d   = '0;
            end
        endcase
    end

    // State, counters and registered outputs; all cleared by sync reset.
    always_ff @(posedge Lock_CLK) begin
        if (Lock_RST) begin
            state_q    <= S_IDLE;
            prog_q     <= '0;
            fail_q     <= '0;
            tmo_q      <= '0;
            lck_q      <= '0;
            kprev_q    <= '0;
            Unlocked   <= 1'b0;
            Locked_out <= 1'b0;
            LED_graph  <= '0;
`ifdef LOCK_REPROGRAM_EN
            code_q     <= CODE;
`endif
        end else begin
            state_q    <= state_d;
            prog_q     <= prog_d;
            fail_q     <= fail_d;
            tmo_q      <= tmo_d;
            lck_q      <= lck_d;
            kprev_q    <= Key_IN;
            Unlocked   <= (state_d == S_OPEN);
            Locked_out <= (state_d == S_LOCK);
            LED_graph  <= therm(prog_d);
`ifdef LOCK_REPROGRAM_EN
            code_q     <= code_d;
`endif
        end
    end

    assign Fail_cnt = fail_q;
    assign Progress = prog_q;

endmodule
